// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM block: resolution, duty type and
// the prescaler counter width helper.
package pwm_pkg;

    localparam int PWM_BITS = 8;

    typedef logic [PWM_BITS-1:0] duty_t;

    localparam duty_t CNT_MAX = {PWM_BITS{1'b1}};

    function automatic int presc_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Duty request in, PWM waveform out; the driver side is master, the PWM core is slave.
interface pwm_if;
    import pwm_pkg::*;

    duty_t duty_cycle_in;
    logic  pwm_out;

    modport master (output duty_cycle_in, input  pwm_out);
    modport slave  (input  duty_cycle_in, output pwm_out);

endinterface

// File: rtl/pwm_prescaler.sv
// Divides the system clock into a one-cycle step tick every CLK_DIV clocks.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic i_en,
    output logic o_tick
);

    localparam int            W    = presc_w(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_presc;
    logic         w_last;

    assign w_last = (r_presc == LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_presc <= '0;
        end else if (i_en) begin
            r_presc <= w_last ? '0 : r_presc + W'(1);
        end
    end

endmodule

// File: rtl/pwm.sv
// 8-bit PWM: step counter, per-period duty latch and registered compare output.
module pwm
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk_in,
    input  logic reset_in,
    pwm_if.slave bus
);

    logic  w_tick;
    logic  w_en;
    logic  w_wrap;
    logic  w_load;
    duty_t w_cnt_nx;
    duty_t w_duty_nx;

    duty_t r_cnt;
    duty_t r_duty;
    logic  r_first;
    logic  r_pwm;

    // Counters hold on the first edge after reset so that edge is step 0 of a
    // full-length period rather than eating one clock of the first pulse.
    assign w_en = ~r_first;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .i_en     (w_en),
        .o_tick   (w_tick)
    );

    assign w_wrap = w_tick && (r_cnt == CNT_MAX);
    assign w_load = r_first || w_wrap;

    always_comb begin
        w_cnt_nx  = r_cnt;
        w_duty_nx = r_duty;
        if (w_tick) begin
            w_cnt_nx = r_cnt + duty_t'(1);
        end
        if (w_load) begin
            w_duty_nx = bus.duty_cycle_in;
        end
    end

    // Comparing next-state values keeps pwm_out == (cnt < duty_q) every cycle.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cnt   <= '0;
            r_duty  <= '0;
            r_first <= 1'b1;
            r_pwm   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nx;
            r_duty  <= w_duty_nx;
            r_first <= 1'b0;
            r_pwm   <= (w_cnt_nx < w_duty_nx);
        end
    end

    assign bus.pwm_out = r_pwm;

endmodule

// File: tb/tb_pwm.sv
// Bench for pwm: two CLK_DIV=50 instances for pulse shape/latency/reset,
// one CLK_DIV=1 instance driven from a duty vector table.
module tb_pwm;
    import pwm_pkg::*;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_if u_if0 ();
    pwm_if u_if1 ();
    pwm_if u_if2 ();

    pwm #(.CLK_DIV(50)) dut0 (.clk_in(clk), .reset_in(rst0), .bus(u_if0));
    pwm #(.CLK_DIV(50)) dut1 (.clk_in(clk), .reset_in(rst1), .bus(u_if1));
    pwm #(.CLK_DIV(1))  dut2 (.clk_in(clk), .reset_in(rst2), .bus(u_if2));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Pulse-shape monitors: record high and low run lengths in clocks.
    logic p0_prev = 1'b0, p1_prev = 1'b0;
    int   r0_t, f0_t, r1_t, f1_t;
    bit   f0_seen = 1'b0, f1_seen = 1'b0;
    int   hi0[$], lo0[$], hi1[$], lo1[$];

    always @(negedge clk) begin
        if (u_if0.pwm_out && !p0_prev) begin
            if (f0_seen) lo0.push_back(cyc - f0_t);
            r0_t = cyc;
        end
        if (!u_if0.pwm_out && p0_prev) begin
            hi0.push_back(cyc - r0_t);
            f0_t = cyc;
            f0_seen = 1'b1;
        end
        p0_prev = u_if0.pwm_out;
    end

    always @(negedge clk) begin
        if (u_if1.pwm_out && !p1_prev) begin
            if (f1_seen) lo1.push_back(cyc - f1_t);
            r1_t = cyc;
        end
        if (!u_if1.pwm_out && p1_prev) begin
            hi1.push_back(cyc - r1_t);
            f1_t = cyc;
            f1_seen = 1'b1;
        end
        p1_prev = u_if1.pwm_out;
    end

    typedef struct {
        int duty;
        int hi;
        int rises;
    } vec_t;

    initial begin
        u_if0.duty_cycle_in = 8'd128;
        u_if1.duty_cycle_in = 8'd200;
        u_if2.duty_cycle_in = 8'd1;
        fork
            // Duty 128, async reset mid-pulse, then 128 -> 25 change mid-period.
            begin
                repeat (3) @(posedge clk);
                #1 chk("rst_state0", int'(u_if0.pwm_out), 0);
                @(negedge clk) rst0 = 1'b0;
                @(posedge clk) #1 chk("first_rise0", int'(u_if0.pwm_out), 1);
                repeat (2999) @(posedge clk);
                #1 chk("mid_high0", int'(u_if0.pwm_out), 1);
                #2 rst0 = 1'b1;
                #1 chk("async_rst0", int'(u_if0.pwm_out), 0);
                repeat (3) @(negedge clk);
                rst0 = 1'b0;
                @(posedge clk) #1 chk("rerise0", int'(u_if0.pwm_out), 1);
                @(negedge clk) #1 begin
                    hi0.delete();
                    lo0.delete();
                end
                repeat (15799) @(posedge clk);
                #1 u_if0.duty_cycle_in = 8'd25;
                repeat (22610) @(posedge clk);
                #1;
                chk("p1_hi_128", hi0.size() > 0 ? hi0[0] : -1, 6400);
                chk("p1_lo_128", lo0.size() > 0 ? lo0[0] : -1, 6400);
                chk("p2_hi_ignored_change", hi0.size() > 1 ? hi0[1] : -1, 6400);
                chk("p2_lo_128", lo0.size() > 1 ? lo0[1] : -1, 6400);
                chk("p3_hi_25", hi0.size() > 2 ? hi0[2] : -1, 1250);
                chk("p3_lo_25", lo0.size() > 2 ? lo0[2] : -1, 11550);
            end
            // Duty 200, then 0 (no rise), then 255 (50-clock low).
            begin
                repeat (3) @(posedge clk);
                #1 chk("rst_state1", int'(u_if1.pwm_out), 0);
                @(negedge clk) rst1 = 1'b0;
                @(posedge clk) #1 chk("first_rise1", int'(u_if1.pwm_out), 1);
                @(negedge clk) #1 begin
                    hi1.delete();
                    lo1.delete();
                end
                repeat (12999) @(posedge clk);
                #1 u_if1.duty_cycle_in = 8'd0;
                repeat (13000) @(posedge clk);
                #1 u_if1.duty_cycle_in = 8'd255;
                repeat (25210) @(posedge clk);
                #1;
                chk("p1_hi_200", hi1.size() > 0 ? hi1[0] : -1, 10000);
                chk("p1_lo_200", lo1.size() > 0 ? lo1[0] : -1, 2800);
                chk("p2_hi_200", hi1.size() > 1 ? hi1[1] : -1, 10000);
                chk("p2p3_lo_duty0", lo1.size() > 1 ? lo1[1] : -1, 15600);
                chk("p4_hi_255", hi1.size() > 2 ? hi1[2] : -1, 12750);
                chk("p4_lo_255", lo1.size() > 2 ? lo1[2] : -1, 50);
                chk("n_pulses1", hi1.size(), 3);
            end
            // CLK_DIV = 1: any 256-clock window holds exactly duty high clocks.
            begin
                vec_t tbl[7];
                tbl[0] = '{1,   1,   1};
                tbl[1] = '{0,   0,   0};
                tbl[2] = '{255, 255, 1};
                tbl[3] = '{128, 128, 1};
                tbl[4] = '{2,   2,   1};
                tbl[5] = '{254, 254, 1};
                tbl[6] = '{25,  25,  1};
                repeat (3) @(posedge clk);
                @(negedge clk) rst2 = 1'b0;
                @(posedge clk) #1 chk("first_rise2", int'(u_if2.pwm_out), 1);
                @(posedge clk) #1 chk("one_clk_high2", int'(u_if2.pwm_out), 0);
                for (int i = 0; i < 7; i++) begin
                    int   hi_n;
                    int   rise_n;
                    logic prev;
                    u_if2.duty_cycle_in = 8'(tbl[i].duty);
                    repeat (300) @(posedge clk);
                    @(negedge clk) prev = u_if2.pwm_out;
                    hi_n   = 0;
                    rise_n = 0;
                    for (int k = 0; k < 256; k++) begin
                        @(negedge clk);
                        hi_n += int'(u_if2.pwm_out);
                        if (u_if2.pwm_out && !prev) rise_n++;
                        prev = u_if2.pwm_out;
                    end
                    chk($sformatf("div1_hi_d%0d", tbl[i].duty), hi_n, tbl[i].hi);
                    chk($sformatf("div1_rises_d%0d", tbl[i].duty), rise_n, tbl[i].rises);
                end
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
